// File: rtl/cl_decode_pipe.sv
// cl_decode_pkg: opcode encoding and instruction record shared by the decode
// stage and anything that talks to it.
package cl_decode_pkg;

  typedef enum logic [5:0] {
    kADDU  = 6'd0,
    kSUBU  = 6'd1,
    kSLLV  = 6'd2,
    kSRAV  = 6'd3,
    kSRLV  = 6'd4,
    kAND   = 6'd5,
    kOR    = 6'd6,
    kNOR   = 6'd7,
    kSLT   = 6'd8,
    kSLTU  = 6'd9,
    kMOV   = 6'd10,
    kROL   = 6'd11,
    kBXOR  = 6'd12,
    kJALR  = 6'd13,
    kLW    = 6'd14,
    kLBU   = 6'd15,
    kSW    = 6'd16,
    kSB    = 6'd17,
    kBEQZ  = 6'd18,
    kBNEQZ = 6'd19,
    kJR    = 6'd20,
    kNOP   = 6'd21
  } opcode_e;

  typedef struct packed {
    opcode_e    opcode;
    logic [4:0] rd;
    logic [4:0] rs;
    logic [4:0] rt;
  } instruction_s;

endpackage

// cl_decode_pipe: single-entry decode stage with an in-flight memory-op limiter.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   instruction_i         : instruction offered by fetch
//   instr_valid_i/ready_o : fetch-side handshake
//   valid_o / ready_i     : downstream handshake for the held instruction
//   flush_i               : drop the held instruction
//   mem_done_i            : one outstanding memory op retired this cycle
//   is_*_o, op_writes_rf_o: registered decode flags of the held instruction
//   instruction_o         : held instruction
//   inflight_o            : outstanding memory-op count
//   stall_o               : offered mem op blocked by a full in-flight count
//   err_o                 : sticky underflow flag (mem_done_i with nothing outstanding)
module cl_decode_pipe
  import cl_decode_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  instruction_s     instruction_i,
  input  logic             instr_valid_i,
  output logic             instr_ready_o,
  output logic             valid_o,
  input  logic             ready_i,
  input  logic             flush_i,
  input  logic             mem_done_i,
  output logic             is_load_op_o,
  output logic             op_writes_rf_o,
  output logic             is_store_op_o,
  output logic             is_mem_op_o,
  output logic             is_byte_op_o,
  output instruction_s     instruction_o,
  output logic [CNT_W-1:0] inflight_o,
  output logic             stall_o,
  output logic             err_o
);

  // Two spare bits let the raw sum go negative without wrapping.
  localparam int SW = CNT_W + 2;

  typedef struct packed {
    logic load;
    logic wrf;
    logic store;
    logic mem;
    logic byte_op;
  } flags_t;

  function automatic flags_t decode(input opcode_e op);
    flags_t f;
    f = '0;
    case (op)
      kLW:  begin f.load = 1'b1; f.wrf = 1'b1; f.mem = 1'b1; end
      kLBU: begin f.load = 1'b1; f.wrf = 1'b1; f.mem = 1'b1; f.byte_op = 1'b1; end
      kSW:  begin f.store = 1'b1; f.mem = 1'b1; end
      kSB:  begin f.store = 1'b1; f.mem = 1'b1; f.byte_op = 1'b1; end
      kADDU, kSUBU, kSLLV, kSRAV, kSRLV, kAND, kOR, kNOR,
      kSLT, kSLTU, kMOV, kROL, kBXOR, kJALR: f.wrf = 1'b1;
      default: f = '0;
    endcase
    return f;
  endfunction

  logic                   vld_p0;
  instruction_s           instr_p0;
  flags_t                 flags_p0;
  logic [CNT_W-1:0]       cnt_p0;
  logic                   err_p0;

  flags_t                 flags_in;
  logic                   mem_in;
  logic                   accept;
  logic                   inc;
  logic                   dec;
  logic                   fdec;
  logic signed [SW-1:0]   cnt_sum;
  logic [CNT_W-1:0]       cnt_nxt;
  logic                   underflow;

  assign flags_in = decode(instruction_i.opcode);
  assign mem_in   = flags_in.mem;

  // The limit is judged on the registered count only; a retiring op frees
  // its slot for the following cycle, never the current one.
  assign stall_o       = instr_valid_i && mem_in && (cnt_p0 == CNT_W'(MAX_INFLIGHT));
  assign instr_ready_o = (!vld_p0 || ready_i) && !stall_o && !flush_i;
  assign accept        = instr_valid_i && instr_ready_o;

  // A flushed mem op that downstream did not take never reaches memory,
  // so its slot is returned here.
  assign inc  = accept && mem_in;
  assign dec  = mem_done_i && (cnt_p0 != '0);
  assign fdec = flush_i && vld_p0 && flags_p0.mem && !ready_i;

  always_comb begin
    cnt_sum   = SW'(cnt_p0) + SW'(inc) - SW'(dec) - SW'(fdec);
    underflow = (mem_done_i && (cnt_p0 == '0)) || (cnt_sum < 0);
    cnt_nxt   = (cnt_sum < 0) ? '0 : cnt_sum[CNT_W-1:0];
  end

  // ---- stage p0: held instruction, flags and counter ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0   <= 1'b0;
      instr_p0 <= '0;
      flags_p0 <= '0;
      cnt_p0   <= '0;
      err_p0   <= 1'b0;
    end else begin
      if (accept) begin
        vld_p0   <= 1'b1;
        instr_p0 <= instruction_i;
        flags_p0 <= flags_in;
      end else if (flush_i || ready_i) begin
        vld_p0   <= 1'b0;
      end
      cnt_p0 <= cnt_nxt;
      if (underflow) err_p0 <= 1'b1;
    end
  end

  assign valid_o        = vld_p0;
  assign instruction_o  = instr_p0;
  assign is_load_op_o   = flags_p0.load;
  assign op_writes_rf_o = flags_p0.wrf;
  assign is_store_op_o  = flags_p0.store;
  assign is_mem_op_o    = flags_p0.mem;
  assign is_byte_op_o   = flags_p0.byte_op;
  assign inflight_o     = cnt_p0;
  assign err_o          = err_p0;

endmodule

// File: tb/tb_cl_decode_pipe.sv
module tb_cl_decode_pipe;
  import cl_decode_pkg::*;

  localparam int MAXI = 4;
  localparam int CW   = $clog2(MAXI + 1);

  logic          clk = 1'b0;
  logic          reset;
  instruction_s  instruction_i;
  logic          instr_valid_i;
  logic          instr_ready_o;
  logic          valid_o;
  logic          ready_i;
  logic          flush_i;
  logic          mem_done_i;
  logic          is_load_op_o, op_writes_rf_o, is_store_op_o, is_mem_op_o, is_byte_op_o;
  instruction_s  instruction_o;
  logic [CW-1:0] inflight_o;
  logic          stall_o;
  logic          err_o;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  cl_decode_pipe #(.MAX_INFLIGHT(MAXI), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .instruction_i(instruction_i), .instr_valid_i(instr_valid_i),
    .instr_ready_o(instr_ready_o), .valid_o(valid_o), .ready_i(ready_i),
    .flush_i(flush_i), .mem_done_i(mem_done_i),
    .is_load_op_o(is_load_op_o), .op_writes_rf_o(op_writes_rf_o),
    .is_store_op_o(is_store_op_o), .is_mem_op_o(is_mem_op_o),
    .is_byte_op_o(is_byte_op_o), .instruction_o(instruction_o),
    .inflight_o(inflight_o), .stall_o(stall_o), .err_o(err_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic instruction_s mk(input opcode_e op);
    instruction_s s;
    s.opcode = op;
    s.rd     = 5'(op) + 5'd1;
    s.rs     = 5'd3;
    s.rt     = ~s.rd;
    return s;
  endfunction

  // Opcode classes straight from the decode rules.
  function automatic bit m_load(input opcode_e op);  return op inside {kLW, kLBU}; endfunction
  function automatic bit m_store(input opcode_e op); return op inside {kSW, kSB}; endfunction
  function automatic bit m_mem(input opcode_e op);   return m_load(op) || m_store(op); endfunction
  function automatic bit m_byte(input opcode_e op);  return op inside {kLBU, kSB}; endfunction
  function automatic bit m_wrf(input opcode_e op);
    return op inside {kADDU, kSUBU, kSLLV, kSRAV, kSRLV, kAND, kOR, kNOR,
                      kSLT, kSLTU, kMOV, kROL, kBXOR, kJALR, kLW, kLBU};
  endfunction

  // Behavioural model state
  bit           m_valid = 1'b0;
  bit           m_err   = 1'b0;
  int           m_cnt   = 0;
  instruction_s m_instr = '0;
  bit           m_stall, m_rdy, m_acc;
  int           m_nxt;

  always @(negedge clk) begin
    if (chk_en) begin
      m_stall = instr_valid_i && m_mem(instruction_i.opcode) && (m_cnt == MAXI);
      m_rdy   = (!m_valid || ready_i) && !m_stall && !flush_i;
      chk("valid_o", 32'(valid_o), 32'(m_valid));
      chk("inflight_o", 32'(inflight_o), 32'(m_cnt));
      chk("err_o", 32'(err_o), 32'(m_err));
      chk("stall_o", 32'(stall_o), 32'(m_stall));
      chk("instr_ready_o", 32'(instr_ready_o), 32'(m_rdy));
      if (m_valid) begin
        chk("instruction_o", 32'(instruction_o), 32'(m_instr));
        chk("is_load_op_o", 32'(is_load_op_o), 32'(m_load(m_instr.opcode)));
        chk("op_writes_rf_o", 32'(op_writes_rf_o), 32'(m_wrf(m_instr.opcode)));
        chk("is_store_op_o", 32'(is_store_op_o), 32'(m_store(m_instr.opcode)));
        chk("is_mem_op_o", 32'(is_mem_op_o), 32'(m_mem(m_instr.opcode)));
        chk("is_byte_op_o", 32'(is_byte_op_o), 32'(m_byte(m_instr.opcode)));
      end
      if (reset) begin
        m_valid = 1'b0; m_err = 1'b0; m_cnt = 0; m_instr = '0;
      end else begin
        m_acc = instr_valid_i && m_rdy;
        m_nxt = m_cnt;
        if (m_acc && m_mem(instruction_i.opcode)) m_nxt++;
        if (mem_done_i && m_cnt != 0) m_nxt--;
        if (mem_done_i && m_cnt == 0) m_err = 1'b1;
        if (flush_i && m_valid && m_mem(m_instr.opcode) && !ready_i) m_nxt--;
        if (m_nxt < 0) begin m_nxt = 0; m_err = 1'b1; end
        m_cnt = m_nxt;
        if (m_acc) begin
          m_valid = 1'b1;
          m_instr = instruction_i;
        end else if (flush_i || ready_i) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input opcode_e op, input logic iv, input logic rdy,
                       input logic fl, input logic md);
    instruction_i = mk(op);
    instr_valid_i = iv;
    ready_i       = rdy;
    flush_i       = fl;
    mem_done_i    = md;
  endtask

  initial begin
    reset = 1'b1;
    drive(kNOP, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_en = 1'b1;
    chk("rst valid_o", 32'(valid_o), 32'd0);
    chk("rst inflight_o", 32'(inflight_o), 32'd0);
    chk("rst err_o", 32'(err_o), 32'd0);
    chk("rst instruction_o", 32'(instruction_o), 32'd0);
    reset = 1'b0;

    // back-to-back ADDU then LW
    drive(kADDU, 1'b1, 1'b1, 1'b0, 1'b0);
    #1 chk("b2b ready", 32'(instr_ready_o), 32'd1);
    tick();
    chk("b2b c1 valid", 32'(valid_o), 32'd1);
    chk("b2b c1 wrf", 32'(op_writes_rf_o), 32'd1);
    chk("b2b c1 load", 32'(is_load_op_o), 32'd0);
    drive(kLW, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("b2b c2 valid", 32'(valid_o), 32'd1);
    chk("b2b c2 wrf", 32'(op_writes_rf_o), 32'd1);
    chk("b2b c2 load", 32'(is_load_op_o), 32'd1);
    chk("b2b c2 inflight", 32'(inflight_o), 32'd1);
    drive(kNOP, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("b2b drain valid", 32'(valid_o), 32'd0);
    drive(kNOP, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    chk("b2b done inflight", 32'(inflight_o), 32'd0);

    // in-flight limit
    for (int i = 0; i < 4; i++) begin
      drive(kSW, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    chk("lim inflight4", 32'(inflight_o), 32'd4);
    drive(kSB, 1'b1, 1'b1, 1'b0, 1'b0);
    #1 chk("lim stall", 32'(stall_o), 32'd1);
    chk("lim ready", 32'(instr_ready_o), 32'd0);
    tick();
    chk("lim not accepted", 32'(valid_o), 32'd0);
    drive(kSB, 1'b1, 1'b1, 1'b0, 1'b1);
    #1 chk("lim stall w/ done", 32'(stall_o), 32'd1);
    tick();
    chk("lim inflight3", 32'(inflight_o), 32'd3);
    drive(kSB, 1'b1, 1'b1, 1'b0, 1'b0);
    #1 chk("lim unstall", 32'(instr_ready_o), 32'd1);
    tick();
    chk("lim sb valid", 32'(valid_o), 32'd1);
    chk("lim sb opcode", 32'(instruction_o.opcode), 32'(kSB));
    chk("lim sb byte", 32'(is_byte_op_o), 32'd1);
    chk("lim inflight back4", 32'(inflight_o), 32'd4);
    for (int i = 0; i < 4; i++) begin
      drive(kNOP, 1'b0, 1'b1, 1'b0, 1'b1);
      tick();
    end
    chk("lim drained", 32'(inflight_o), 32'd0);

    // backpressure
    drive(kLBU, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(kADDU, 1'b1, 1'b0, 1'b0, 1'b0);
      #1 chk("bp ready", 32'(instr_ready_o), 32'd0);
      chk("bp instr", 32'(instruction_o), 32'(mk(kLBU)));
      chk("bp byte", 32'(is_byte_op_o), 32'd1);
      tick();
    end
    chk("bp still held", 32'(instruction_o.opcode), 32'(kLBU));
    drive(kNOP, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(kNOP, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    chk("bp drained", 32'(inflight_o), 32'd0);

    // flush of a held load
    drive(kLW, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("fl inflight1", 32'(inflight_o), 32'd1);
    drive(kADDU, 1'b1, 1'b0, 1'b1, 1'b0);
    #1 chk("fl ready", 32'(instr_ready_o), 32'd0);
    tick();
    chk("fl valid", 32'(valid_o), 32'd0);
    chk("fl inflight0", 32'(inflight_o), 32'd0);

    // simultaneous accept + done, then underflow
    drive(kLW, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    chk("sim inflight2", 32'(inflight_o), 32'd2);
    drive(kSW, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    chk("sim inflight stays2", 32'(inflight_o), 32'd2);
    drive(kNOP, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    tick();
    chk("sim drained", 32'(inflight_o), 32'd0);
    chk("sim err before", 32'(err_o), 32'd0);
    tick();
    chk("sim err set", 32'(err_o), 32'd1);
    chk("sim inflight floor", 32'(inflight_o), 32'd0);
    drive(kNOP, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    chk("sim err sticky", 32'(err_o), 32'd1);

    // done and flush together at count 1 clamp to zero
    drive(kLW, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(kNOP, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    chk("clamp inflight", 32'(inflight_o), 32'd0);
    chk("clamp valid", 32'(valid_o), 32'd0);

    // reset mid-stream
    for (int i = 0; i < 3; i++) begin
      drive(kLW, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    chk("mid valid", 32'(valid_o), 32'd1);
    chk("mid inflight3", 32'(inflight_o), 32'd3);
    reset = 1'b1;
    drive(kSW, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    chk("rst2 valid", 32'(valid_o), 32'd0);
    chk("rst2 inflight", 32'(inflight_o), 32'd0);
    chk("rst2 err", 32'(err_o), 32'd0);
    chk("rst2 instr", 32'(instruction_o), 32'd0);
    chk("rst2 flags", 32'({is_load_op_o, op_writes_rf_o, is_store_op_o,
                           is_mem_op_o, is_byte_op_o}), 32'd0);
    reset = 1'b0;
    drive(kNOP, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
